// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: state encodings, BCD time packing, default timing.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package alarm_pkg;

   // FSM state encodings (2-bit, also the externally visible state code)
   localparam logic [1:0] DISARMED = 2'd0;
   localparam logic [1:0] ARMED    = 2'd1;
   localparam logic [1:0] RINGING  = 2'd2;
   localparam logic [1:0] SNOOZE   = 2'd3;

   // BCD time word: {hourMSB,hourLSB,minMSB,minLSB,secMSB,secLSB}, one nibble each
   localparam int TIME_W       = 24;
   localparam int HOUR_MSB_OFS = 20;
   localparam int HOUR_LSB_OFS = 16;
   localparam int MIN_MSB_OFS  = 12;
   localparam int MIN_LSB_OFS  = 8;
   localparam int SEC_MSB_OFS  = 4;
   localparam int SEC_LSB_OFS  = 0;

   // Width of the shared ring/snooze countdown
   localparam int CNT_W = 16;

   // Default timing
   localparam int RING_SEC_DEF   = 60;
   localparam int SNOOZE_SEC_DEF = 300;
   localparam int TONE_DIV_DEF   = 50000;

   // Assemble a packed BCD time word from its six digits
   function automatic logic [TIME_W-1:0] pack_time(input logic [3:0] h1, input logic [3:0] h0,
                                                   input logic [3:0] m1, input logic [3:0] m0,
                                                   input logic [3:0] s1, input logic [3:0] s0);
      logic [TIME_W-1:0] t;
      t = '0;
      t[HOUR_MSB_OFS +: 4] = h1;
      t[HOUR_LSB_OFS +: 4] = h0;
      t[MIN_MSB_OFS  +: 4] = m1;
      t[MIN_LSB_OFS  +: 4] = m0;
      t[SEC_MSB_OFS  +: 4] = s1;
      t[SEC_LSB_OFS  +: 4] = s0;
      return t;
   endfunction

endpackage

// File: rtl/alarm_controller_tone_gen.sv
// Buzzer square-wave generator: toggles its output every TONE_DIV cycles while enabled.
// Latency: first rising edge of out TONE_DIV cycles after en rises.
// Backpressure: none; clears immediately when en drops.
// Ports: clk, reset (sync, active-high), en (run enable), out (square wave, low when disabled).
module tone_gen
   import alarm_pkg::*;
#(
   parameter int TONE_DIV = TONE_DIV_DEF
)(
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic out
);

   localparam int             W    = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
   localparam logic [W-1:0]   LAST = W'(TONE_DIV - 1);

   logic [W-1:0] tcnt;
   logic         buz;

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         tcnt <= '0;
         buz  <= 1'b0;
      end else if (tcnt == LAST) begin
         tcnt <= '0;
         buz  <= ~buz;
      end else begin
         tcnt <= tcnt + 1'b1;
      end
   end

   // Gating by en keeps the tone silent on the cycle right after leaving RINGING,
   // before the registered clear has taken effect. en is itself a registered decode.
   assign out = buz & en;

endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencer: time-match edge detect, disarmed/armed/ringing/snooze FSM, ring/snooze countdown, buzzer tone.
// Latency: key pulses take effect at the sampling edge; time match rings one edge after cur_time becomes equal.
// Backpressure: none; key pulses are single-cycle events and never stalled.
// Ports: clk, reset (sync, active-high), sec_tick, cur_time/alarm_time (BCD), settime,
//        arm_toggle/snooze/dismiss (key pulses) -> state, armed, ringing, snoozing, buzzer.
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int RING_SEC   = RING_SEC_DEF,
   parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
   parameter int TONE_DIV   = TONE_DIV_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              sec_tick,
   input  logic [TIME_W-1:0] cur_time,
   input  logic [TIME_W-1:0] alarm_time,
   input  logic              settime,
   input  logic              arm_toggle,
   input  logic              snooze,
   input  logic              dismiss,
   output logic [1:0]        state,
   output logic              armed,
   output logic              ringing,
   output logic              snoozing,
   output logic              buzzer
);

   localparam logic [CNT_W-1:0] RING_CNT   = CNT_W'(RING_SEC);
   localparam logic [CNT_W-1:0] SNOOZE_CNT = CNT_W'(SNOOZE_SEC);

   logic             match;
   logic             match_q;
   logic             rise;
   logic [CNT_W-1:0] cnt;

   // Only the first cycle of equality triggers, so arming while already equal does not ring.
   assign match = (cur_time == alarm_time);
   assign rise  = match & ~match_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= DISARMED;
         match_q <= 1'b0;
         cnt     <= '0;
      end else begin
         match_q <= match;
         case (state)
            DISARMED: begin
               if (arm_toggle) state <= ARMED;
            end
            ARMED: begin
               if (arm_toggle) begin
                  state <= DISARMED;
               end else if (rise && !settime) begin
                  state <= RINGING;
                  cnt   <= RING_CNT;      // a coincident sec_tick is not counted
               end
            end
            RINGING: begin
               if (arm_toggle) begin
                  state <= DISARMED;
                  cnt   <= '0;
               end else if (dismiss) begin
                  state <= ARMED;
                  cnt   <= '0;
               end else if (snooze) begin
                  state <= SNOOZE;
                  cnt   <= SNOOZE_CNT;
               end else if (sec_tick) begin
                  if (cnt == CNT_W'(1)) begin
                     state <= ARMED;      // ring timed out
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            SNOOZE: begin
               if (arm_toggle) begin
                  state <= DISARMED;
                  cnt   <= '0;
               end else if (dismiss) begin
                  state <= ARMED;
                  cnt   <= '0;
               end else if (sec_tick) begin
                  if (cnt == CNT_W'(1)) begin
                     state <= RINGING;    // snooze over, ring again
                     cnt   <= RING_CNT;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign armed    = (state != DISARMED);
   assign ringing  = (state == RINGING);
   assign snoozing = (state == SNOOZE);

   tone_gen #(
      .TONE_DIV (TONE_DIV)
   ) u_tone_gen (
      .clk   (clk),
      .reset (reset),
      .en    (ringing),
      .out   (buzzer)
   );

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: table of single-cycle vectors plus hand sequences
// for tone timing, ring timeout, snooze re-ring, key priority and mid-snooze reset.
module tb_alarm_controller;
   import alarm_pkg::*;

   localparam int TD = 8;
   localparam int RS = 60;
   localparam int SS = 300;

   logic              clk = 1'b0;
   logic              reset;
   logic              sec_tick;
   logic [TIME_W-1:0] cur_time;
   logic [TIME_W-1:0] alarm_time;
   logic              settime;
   logic              arm_toggle;
   logic              snooze;
   logic              dismiss;
   logic [1:0]        state;
   logic              armed;
   logic              ringing;
   logic              snoozing;
   logic              buzzer;

   int vec_cnt = 0;
   int mis_cnt = 0;

   always #5 clk = ~clk;

   alarm_controller #(
      .RING_SEC   (RS),
      .SNOOZE_SEC (SS),
      .TONE_DIV   (TD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sec_tick   (sec_tick),
      .cur_time   (cur_time),
      .alarm_time (alarm_time),
      .settime    (settime),
      .arm_toggle (arm_toggle),
      .snooze     (snooze),
      .dismiss    (dismiss),
      .state      (state),
      .armed      (armed),
      .ringing    (ringing),
      .snoozing   (snoozing),
      .buzzer     (buzzer)
   );

   typedef struct {
      logic              arm;
      logic              snz;
      logic              dis;
      logic              st;
      logic [TIME_W-1:0] cur;
      logic [1:0]        exp_state;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [TIME_W-1:0] hms(input int h, input int m, input int s);
      return pack_time(4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10));
   endfunction

   function automatic void add(input logic a, input logic s, input logic d, input logic st,
                               input logic [TIME_W-1:0] cur, input logic [1:0] es);
      vec_t v;
      v.arm = a; v.snz = s; v.dis = d; v.st = st; v.cur = cur; v.exp_state = es;
      tbl.push_back(v);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected flag outputs are decoded from the expected state code
   task automatic check_state(input string name, input logic [1:0] es);
      logic [4:0] exp_v;
      logic [4:0] act_v;
      exp_v = {es, (es != 2'd0), (es == 2'd2), (es == 2'd3)};
      act_v = {state, armed, ringing, snoozing};
      vec_cnt++;
      if (act_v !== exp_v) begin
         mis_cnt++;
         $display("FAIL %s: {state,armed,ringing,snoozing} got %b expected %b", name, act_v, exp_v);
      end
   endtask

   task automatic check_buz(input string name, input logic eb);
      vec_cnt++;
      if (buzzer !== eb) begin
         mis_cnt++;
         $display("FAIL %s: buzzer got %b expected %b", name, buzzer, eb);
      end
   endtask

   // n sec_tick pulses separated by an idle cycle; state checked after each pulse
   task automatic ticks(input int n, input logic [1:0] es, input string name);
      for (int i = 0; i < n; i++) begin
         sec_tick = 1'b1;
         step();
         sec_tick = 1'b0;
         check_state($sformatf("%s_%0d", name, i + 1), es);
         step();
      end
   endtask

   initial begin
      // arm, snooze, dismiss, settime, cur_time, expected state
      add(0, 0, 0, 0, hms(7, 0, 0), 2'd0);  // 0  idle after reset, equal times
      add(1, 0, 0, 0, hms(7, 0, 0), 2'd1);  // 1  arm while equal
      add(0, 0, 0, 0, hms(7, 0, 0), 2'd1);  // 2  no ring while equal
      add(0, 0, 0, 0, hms(7, 0, 0), 2'd1);  // 3
      add(0, 0, 0, 0, hms(6, 59, 59), 2'd1);// 4
      add(0, 0, 0, 0, hms(7, 0, 0), 2'd2);  // 5  match rise -> ring
      add(0, 0, 0, 0, hms(7, 0, 0), 2'd2);  // 6
      add(0, 0, 1, 0, hms(7, 0, 0), 2'd1);  // 7  dismiss
      add(0, 0, 0, 0, hms(7, 0, 1), 2'd1);  // 8
      add(0, 0, 0, 0, hms(7, 0, 0), 2'd2);  // 9  fresh rise
      add(0, 1, 0, 0, hms(7, 0, 0), 2'd3);  // 10 snooze
      add(0, 0, 1, 0, hms(7, 0, 0), 2'd1);  // 11 dismiss from snooze
      add(0, 0, 0, 0, hms(7, 0, 1), 2'd1);  // 12
      add(0, 0, 0, 1, hms(7, 0, 0), 2'd1);  // 13 match during settime
      add(0, 0, 0, 0, hms(7, 0, 0), 2'd1);  // 14 still equal, no new rise
      add(1, 0, 0, 0, hms(7, 0, 0), 2'd0);  // 15 disarm
      add(0, 0, 0, 0, hms(7, 0, 1), 2'd0);  // 16
      add(0, 0, 0, 0, hms(7, 0, 0), 2'd0);  // 17 match while disarmed
      add(1, 0, 0, 0, hms(7, 0, 0), 2'd1);  // 18
      add(0, 0, 0, 0, hms(7, 0, 1), 2'd1);  // 19
      add(0, 0, 0, 0, hms(7, 0, 0), 2'd2);  // 20
      add(1, 0, 1, 0, hms(7, 0, 0), 2'd0);  // 21 arm_toggle beats dismiss
      add(0, 1, 0, 0, hms(7, 0, 0), 2'd0);  // 22 snooze ignored
      add(0, 0, 1, 0, hms(7, 0, 0), 2'd0);  // 23 dismiss ignored
      add(1, 0, 0, 0, hms(7, 0, 0), 2'd1);  // 24
      add(0, 0, 0, 0, hms(7, 0, 1), 2'd1);  // 25
      add(0, 0, 0, 0, hms(7, 0, 0), 2'd2);  // 26
      add(0, 0, 0, 1, hms(7, 0, 0), 2'd2);  // 27 settime does not stop ringing
      add(0, 1, 0, 0, hms(7, 0, 0), 2'd3);  // 28
      add(0, 0, 0, 1, hms(7, 0, 0), 2'd3);  // 29 settime does not affect snooze
      add(1, 0, 0, 0, hms(7, 0, 0), 2'd0);  // 30 disarm from snooze

      reset = 1'b1; sec_tick = 1'b0; settime = 1'b0;
      arm_toggle = 1'b0; snooze = 1'b0; dismiss = 1'b0;
      cur_time = hms(7, 0, 0); alarm_time = hms(7, 0, 0);
      step();
      step();
      check_state("reset", 2'd0);
      check_buz("reset_buz", 1'b0);
      reset = 1'b0;

      foreach (tbl[i]) begin
         arm_toggle = tbl[i].arm; snooze = tbl[i].snz; dismiss = tbl[i].dis;
         settime = tbl[i].st; cur_time = tbl[i].cur;
         step();
         check_state($sformatf("vec%0d", i), tbl[i].exp_state);
         check_buz($sformatf("vec%0d_buz", i), 1'b0);
      end
      arm_toggle = 1'b0; snooze = 1'b0; dismiss = 1'b0; settime = 1'b0;

      // Ring entry with a coincident sec_tick, tone timing, then timeout
      arm_toggle = 1'b1; step(); arm_toggle = 1'b0;
      check_state("s1_arm", 2'd1);
      cur_time = hms(7, 0, 1); step();
      cur_time = hms(7, 0, 0); sec_tick = 1'b1; step(); sec_tick = 1'b0;
      check_state("s1_entry", 2'd2);
      for (int i = 1; i <= 3 * TD; i++) begin
         step();
         check_buz($sformatf("tone_%0d", i), ((i / TD) % 2) == 1);
      end
      ticks(RS - 1, 2'd2, "ring");
      ticks(1, 2'd1, "ring_timeout");
      check_buz("timeout_buz", 1'b0);

      // Snooze, re-ring after SS ticks, reloaded ring count, snooze on final tick
      cur_time = hms(7, 0, 1); step();
      cur_time = hms(7, 0, 0); step();
      check_state("s2_entry", 2'd2);
      for (int i = 0; i < TD; i++) step();
      check_buz("s2_buz_high", 1'b1);
      snooze = 1'b1; step(); snooze = 1'b0;
      check_state("s2_snooze", 2'd3);
      check_buz("s2_snooze_buz", 1'b0);
      for (int i = 0; i < TD + 1; i++) step();
      check_buz("s2_snooze_quiet", 1'b0);
      ticks(SS - 1, 2'd3, "snz");
      ticks(1, 2'd2, "snz_rering");
      ticks(RS - 1, 2'd2, "rering");
      snooze = 1'b1; sec_tick = 1'b1; step(); snooze = 1'b0; sec_tick = 1'b0;
      check_state("snooze_final_tick", 2'd3);

      // Reset halfway through a snooze, then no re-trigger until a fresh rise
      ticks(SS / 2, 2'd3, "half_snz");
      reset = 1'b1; step(); reset = 1'b0;
      check_state("mid_snooze_reset", 2'd0);
      check_buz("mid_snooze_reset_buz", 1'b0);
      arm_toggle = 1'b1; step(); arm_toggle = 1'b0;
      check_state("rearm", 2'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check_state($sformatf("rearm_hold_%0d", i), 2'd1);
      end
      snooze = 1'b1; step(); snooze = 1'b0;
      check_state("armed_snooze_ignored", 2'd1);
      dismiss = 1'b1; step(); dismiss = 1'b0;
      check_state("armed_dismiss_ignored", 2'd1);
      cur_time = hms(7, 0, 1); step();
      cur_time = hms(7, 0, 0); step();
      check_state("fresh_rise", 2'd2);
      dismiss = 1'b1; step(); dismiss = 1'b0;
      check_state("final_dismiss", 2'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
      $finish;
   end

endmodule
